dt_res_arb: RTL
===============

Name: dt_res_arb

Overview:
- Round-robin arbiter that shares the single-port distance-transform result memory (res_*; 14-bit address, 8-bit data) between NREQ requesters, e.g. the forward-pass and backward-pass engines.
- Grants one access per cycle, drives registered memory commands and routes read data back to the issuing requester.
- Supports a lock for read-modify-write sequences, with a starvation bound.

Parameters:
- NREQ, 2, number of requesters (2..4).
- MAX_LOCK, 16, maximum consecutive grants one locked requester may hold.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester access request
- lock  in  NREQ  requester wants to keep the grant next cycle
- we  in  NREQ  1 = write, 0 = read
- addr  in  NREQ*14  per-requester address, requester i in bits [14i+13:14i]
- wdata  in  NREQ*8  per-requester write data
- gnt  out  NREQ  one-hot grant, combinational in the request cycle
- rvalid  out  NREQ  one-hot read-data-valid
- rdata  out  8  read data, shared; qualified by rvalid
- res_wr  out  1  memory write strobe
- res_rd  out  1  memory read strobe
- res_addr  out  14  memory address
- res_do  out  8  memory write data
- res_di  in  8  memory read data, valid the cycle after res_rd is high

Behaviour:
- Reset values: res_wr=0, res_rd=0, res_addr=0, res_do=0, rvalid=0, round-robin pointer=0, lock counter=0, state=ARB.
- Reset also discards any in-flight read, so no rvalid follows it.
- Grant timing, cycle t:
  - gnt[i]=1 for at most one i with req[i]=1.
  - At edge t→t+1, res_rd=!we[i], res_wr=we[i], res_addr=addr_i and res_do=wdata_i are registered.
- No grant in a cycle: the next cycle has res_rd=0 and res_wr=0; res_addr and res_do hold their values.
- Read return:
  - rvalid[i] is high in cycle t+2; rdata=res_di passes through combinationally.
  - Read latency is 2 cycles from grant.
  - A write never produces rvalid.
- Back-to-back reads by different requesters return in grant order, one per cycle.
- Round robin:
  - The priority search starts at (last_granted+1) mod NREQ.
  - The pointer updates only on a grant.
  - With all requesters asserting req continuously, grants rotate 0,1,…,NREQ-1,0,…
- State ARB: normal round robin.
  - If the granted requester has lock[i]=1, go to LOCKED with owner=i and lock counter=1.
- State LOCKED: only the owner may be granted; other requests wait with gnt=0.
  - Owner granted: the lock counter increments.
  - Owner drops lock, drops req, or the counter reaches MAX_LOCK: return to ARB. The pointer is set to owner+1, so another waiting requester wins next.
  - Owner holds req without lock: that is its final locked grant.
- Simultaneous events:
  - Reset beats everything.
  - A lock request in the same cycle the forced release occurs is ignored for one arbitration round.
- Requests without a grant must be held stable by the requester; the arbiter keeps no request queue.
- The requester index is tracked per in-flight read in a 2-deep shift register of {valid, idx}.

Decomposition:
- Package dt_pkg:
  - RES_AW=14 and RES_DW=8.
  - arb_state_t enum {ARB, LOCKED}.
  - A function returning the index of the first set bit at or after a start position, with wrap-around.
- Sub-module dt_rr_pick: combinational round-robin picker.
  - Inputs: req vector, start pointer.
  - Outputs: one-hot grant, index, any.
- The top level holds the FSM, lock counter, command registers and read-return pipeline.

Test Plan:
- Only req[0], read, addr=0x0005, memory returns 0x3C:
  - gnt[0] in cycle t.
  - Cycle t+1: res_rd=1, res_addr=0x0005.
  - Cycle t+2: rvalid[0]=1, rdata=0x3C.
- Only req[1], write, addr=0x3FFF, wdata=0xAB: next cycle res_wr=1, res_addr=0x3FFF, res_do=0xAB; no rvalid.
- req=2'b11 held for 6 cycles, both reads: grants 0,1,0,1,0,1; rvalid follows 2 cycles later with matching indices and data.
- Requester 1 holds req and lock for 3 beats while requester 0 requests continuously: gnt[1] for 3 consecutive cycles, then gnt[0].
- MAX_LOCK=4, requester 0 holds lock indefinitely and requester 1 requests: exactly 4 consecutive gnt[0], then gnt[1], then requester 0 may lock again.
- Reset asserted in cycle t+1 of a read: rvalid stays 0, all res_* outputs are 0, and the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/dt_pkg.sv
// dt_pkg: shared definitions for the distance-transform result-memory arbiter.
//   RES_AW / RES_DW : result memory address and data widths
//   IDX_W / MAX_REQ : requester index width and the largest supported NREQ
//   arb_state_t     : arbiter FSM states
//   first_set_from  : wrap-around search for the first set request bit
package dt_pkg;

    localparam int RES_AW  = 14;
    localparam int RES_DW  = 8;
    localparam int IDX_W   = 2;
    localparam int MAX_REQ = 4;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Returns the index of the first set bit of vec at or after start,
    // wrapping at n. When no bit is set the start position is returned and
    // the caller is expected to qualify the result with an "any" flag.
    function automatic logic [IDX_W-1:0] first_set_from(
        input logic [MAX_REQ-1:0] vec,
        input logic [IDX_W-1:0]   start,
        input int                 n
    );
        logic [IDX_W-1:0] res;
        logic             found;
        int               pos;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            pos = int'(start) + k;
            if (pos >= n) begin
                pos = pos - n;
            end
            if ((k < n) && !found && vec[pos[IDX_W-1:0]]) begin
                res   = pos[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dt_rr_pick.sv
// dt_rr_pick: combinational round-robin picker.
//   req   : request vector, one bit per requester
//   start : position where the priority search begins
//   gnt   : one-hot grant to the first requester found
//   idx   : index of that requester
//   any   : at least one request is present
module dt_rr_pick
    import dt_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] start,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [MAX_REQ-1:0] req_pad;

    always_comb begin
        req_pad            = '0;
        req_pad[NREQ-1:0]  = req;
        any                = |req;
        idx                = first_set_from(req_pad, start, NREQ);
        gnt                = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = any && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/dt_res_arb.sv
// dt_res_arb: round-robin arbiter for the single-port distance-transform
// result memory, with lock support for read-modify-write sequences.
//   clk, reset       : clock, synchronous active-high reset
//   req, lock, we    : per-requester request, keep-grant, write select
//   addr, wdata      : per-requester address / write data, packed by index
//   gnt              : one-hot grant, combinational in the request cycle
//   rvalid, rdata    : read return, two cycles after the grant
//   res_wr, res_rd   : registered memory strobes
//   res_addr, res_do : registered memory address / write data
//   res_di           : memory read data, valid the cycle after res_rd
module dt_res_arb
    import dt_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int MAX_LOCK = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        lock,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*RES_AW-1:0] addr,
    input  logic [NREQ*RES_DW-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [RES_DW-1:0]      rdata,
    output logic                   res_wr,
    output logic                   res_rd,
    output logic [RES_AW-1:0]      res_addr,
    output logic [RES_DW-1:0]      res_do,
    input  logic [RES_DW-1:0]      res_di
);

    localparam int            CW      = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

    arb_state_t       state, state_next;
    logic [IDX_W-1:0] owner, owner_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [CW-1:0]    lock_cnt, cnt_next, cnt_inc;
    logic             lock_block, block_next;

    logic [IDX_W-1:0] pick_start, pick_idx, gidx;
    logic [NREQ-1:0]  pick_gnt, owner_oh;
    logic             pick_any, pick_lock, owner_req, owner_lock, grant_any;

    logic             sel_we;
    logic [RES_AW-1:0] sel_addr;
    logic [RES_DW-1:0] sel_wdata;

    logic             rd_v1, rd_v2;
    logic [IDX_W-1:0] rd_i1, rd_i2;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) >= NREQ - 1) ? '0 : i + IDX_W'(1);
    endfunction

    // While locked the search starts just past the owner, so that when the
    // owner lets go in the same cycle a different waiting requester wins.
    assign pick_start = (state == LOCKED) ? next_idx(owner) : ptr;

    dt_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .start (pick_start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            owner_oh[i] = (owner == IDX_W'(i));
        end
        owner_req  = |(req & owner_oh);
        owner_lock = |(lock & owner_oh);
        pick_lock  = |(lock & pick_gnt);
    end

    // Arbitration and lock FSM. lock_block remembers a forced release so the
    // former owner cannot re-lock on the very next arbitration round.
    always_comb begin
        state_next = state;
        owner_next = owner;
        ptr_next   = ptr;
        cnt_inc    = lock_cnt + CW'(1);
        cnt_next   = lock_cnt;
        block_next = lock_block;
        grant_any  = 1'b0;
        gidx       = pick_idx;
        case (state)
            ARB: begin
                if (pick_any) begin
                    grant_any  = 1'b1;
                    ptr_next   = next_idx(pick_idx);
                    block_next = 1'b0;
                    if (pick_lock && (MAX_LOCK > 1) &&
                        !(lock_block && (pick_idx == owner))) begin
                        state_next = LOCKED;
                        owner_next = pick_idx;
                        cnt_next   = CW'(1);
                    end
                end
            end
            LOCKED: begin
                if (owner_req) begin
                    grant_any = 1'b1;
                    gidx      = owner;
                    cnt_next  = cnt_inc;
                    if (!owner_lock || (cnt_inc >= MAX_CNT)) begin
                        state_next = ARB;
                        ptr_next   = next_idx(owner);
                        cnt_next   = '0;
                        block_next = owner_lock;
                    end
                end else begin
                    state_next = ARB;
                    ptr_next   = next_idx(owner);
                    cnt_next   = '0;
                    block_next = 1'b0;
                    if (pick_any) begin
                        grant_any = 1'b1;
                        ptr_next  = next_idx(pick_idx);
                        if (pick_lock && (MAX_LOCK > 1)) begin
                            state_next = LOCKED;
                            owner_next = pick_idx;
                            cnt_next   = CW'(1);
                        end
                    end
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = grant_any && (gidx == IDX_W'(i));
        end
    end

    // Selects the granted requester's command fields for registration.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[i*RES_AW +: RES_AW];
                sel_wdata = wdata[i*RES_DW +: RES_DW];
            end
        end
    end

    // State, command registers and the two-stage read-return tracker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB;
            owner      <= '0;
            ptr        <= '0;
            lock_cnt   <= '0;
            lock_block <= 1'b0;
            res_wr     <= 1'b0;
            res_rd     <= 1'b0;
            res_addr   <= '0;
            res_do     <= '0;
            rd_v1      <= 1'b0;
            rd_i1      <= '0;
            rd_v2      <= 1'b0;
            rd_i2      <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            ptr        <= ptr_next;
            lock_cnt   <= cnt_next;
            lock_block <= block_next;
            res_wr     <= grant_any && sel_we;
            res_rd     <= grant_any && !sel_we;
            if (grant_any) begin
                res_addr <= sel_addr;
                res_do   <= sel_wdata;
            end
            rd_v1 <= grant_any && !sel_we;
            rd_i1 <= gidx;
            rd_v2 <= rd_v1;
            rd_i2 <= rd_i1;
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rvalid[i] = rd_v2 && (rd_i2 == IDX_W'(i));
        end
        rdata = res_di;
    end

endmodule
